// File: rtl/alb_mss_mem_ibp_arb_pkg.sv
// Shared constants and helpers for the two-port IBP memory arbiter.
//   ALB_MSS_MEM_ARB_NPORT : number of upstream IBP ports (2)
//   IdW                   : width of a port ID held in the order queues (1)
//   DataW / MaskW         : IBP data and byte-mask widths (128 / 16)
package alb_mss_mem_ibp_arb_pkg;

  localparam int unsigned ALB_MSS_MEM_ARB_NPORT = 2;
  localparam int unsigned IdW                   = 1;
  localparam int unsigned DataW                 = 128;
  localparam int unsigned MaskW                 = 16;

  typedef logic [IdW-1:0] port_id_t;

  // Winner selection: a lone eligible port wins, a tie goes to the preferred port.
  function automatic port_id_t arb_pick(input logic [ALB_MSS_MEM_ARB_NPORT-1:0] elig,
                                        input port_id_t                         pref);
    if (elig[0] && elig[1]) begin
      return pref;
    end else if (elig[1]) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/alb_mss_mem_arb_idq.sv
// In-order queue of port IDs, one entry per outstanding transaction on one channel.
//   clk, rst_b      : clock, asynchronous active-low reset (queue empties at once)
//   push, push_id   : enqueue the ID of a granted command
//   pop             : dequeue on the response handshake (ignored when empty)
//   full, empty     : occupancy flags
//   head            : ID of the oldest outstanding transaction
module alb_mss_mem_arb_idq
  import alb_mss_mem_ibp_arb_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic     clk,
  input  logic     rst_b,
  input  logic     push,
  input  port_id_t push_id,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output port_id_t head
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  port_id_t        mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  assign full    = (cnt_q == CntW'(Depth));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id;
  end

endmodule

// File: rtl/alb_mss_mem_ibp_arb.sv
// Two-port IBP arbiter in front of one single-port memory controller.
// Grants one single-beat command per cycle (write command and data move together),
// records the grantee in per-channel order queues and steers in-order read and
// write responses back to the originating port.
//   clk, rst_b : clock, asynchronous active-low reset
//   p0_* / p1_*: upstream IBP ports (cmd, wr data, rd response, wr response)
//   m_*        : downstream IBP port towards the memory controller
// Parameters: a_w (address width), OUTST (outstanding reads / writes, power of 2).
// Build option: ALB_MSS_MEM_ARB_FIXED_PRIO_EN makes port 0 win every tie and
// removes the round-robin pointer.
module alb_mss_mem_ibp_arb
  import alb_mss_mem_ibp_arb_pkg::*;
#(
  parameter int unsigned a_w   = 32,
  parameter int unsigned OUTST = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  // port 0
  input  logic             p0_cmd_valid,
  input  logic             p0_cmd_read,
  input  logic             p0_cmd_wrap,
  input  logic             p0_cmd_nonsec,
  input  logic [a_w-1:0]   p0_cmd_addr,
  input  logic [2:0]       p0_cmd_data_size,
  input  logic [3:0]       p0_cmd_burst_size,
  output logic             p0_cmd_accept,
  input  logic             p0_wr_valid,
  input  logic             p0_wr_last,
  input  logic [DataW-1:0] p0_wr_data,
  input  logic [MaskW-1:0] p0_wr_mask,
  output logic             p0_wr_accept,
  output logic             p0_rd_valid,
  output logic             p0_rd_last,
  output logic             p0_rd_excl_ok,
  output logic             p0_err_rd,
  output logic [DataW-1:0] p0_rd_data,
  input  logic             p0_rd_accept,
  output logic             p0_wr_done,
  output logic             p0_wr_excl_done,
  output logic             p0_err_wr,
  input  logic             p0_wr_resp_accept,
  // port 1
  input  logic             p1_cmd_valid,
  input  logic             p1_cmd_read,
  input  logic             p1_cmd_wrap,
  input  logic             p1_cmd_nonsec,
  input  logic [a_w-1:0]   p1_cmd_addr,
  input  logic [2:0]       p1_cmd_data_size,
  input  logic [3:0]       p1_cmd_burst_size,
  output logic             p1_cmd_accept,
  input  logic             p1_wr_valid,
  input  logic             p1_wr_last,
  input  logic [DataW-1:0] p1_wr_data,
  input  logic [MaskW-1:0] p1_wr_mask,
  output logic             p1_wr_accept,
  output logic             p1_rd_valid,
  output logic             p1_rd_last,
  output logic             p1_rd_excl_ok,
  output logic             p1_err_rd,
  output logic [DataW-1:0] p1_rd_data,
  input  logic             p1_rd_accept,
  output logic             p1_wr_done,
  output logic             p1_wr_excl_done,
  output logic             p1_err_wr,
  input  logic             p1_wr_resp_accept,
  // downstream
  output logic             m_cmd_valid,
  output logic             m_cmd_read,
  output logic             m_cmd_wrap,
  output logic             m_cmd_nonsec,
  output logic [a_w-1:0]   m_cmd_addr,
  output logic [2:0]       m_cmd_data_size,
  output logic [3:0]       m_cmd_burst_size,
  input  logic             m_cmd_accept,
  output logic             m_wr_valid,
  output logic             m_wr_last,
  output logic [DataW-1:0] m_wr_data,
  output logic [MaskW-1:0] m_wr_mask,
  input  logic             m_wr_accept,
  input  logic             m_rd_valid,
  input  logic             m_rd_last,
  input  logic             m_rd_excl_ok,
  input  logic             m_err_rd,
  input  logic [DataW-1:0] m_rd_data,
  output logic             m_rd_accept,
  input  logic             m_wr_done,
  input  logic             m_wr_excl_done,
  input  logic             m_err_wr,
  output logic             m_wr_resp_accept
);

  logic [1:0] cmd_valid, cmd_read, wr_valid;
  logic [1:0] elig_rd, elig_wr, elig;
  logic       rdq_full, rdq_empty, wrq_full, wrq_empty;
  port_id_t   rdq_head, wrq_head;
  port_id_t   winner, pref;
  logic       win_wr, cmd_hs, take;
  logic       rd_resp, wr_resp, rd_pop, wr_pop;
  logic [1:0] rd_sel, wr_sel;

  assign cmd_valid = {p1_cmd_valid, p0_cmd_valid};
  assign cmd_read  = {p1_cmd_read, p0_cmd_read};
  assign wr_valid  = {p1_wr_valid, p0_wr_valid};

  // A full queue only blocks its own channel.
  assign elig_rd = cmd_valid & cmd_read & {2{~rdq_full}};
  assign elig_wr = cmd_valid & ~cmd_read & wr_valid & {2{~wrq_full}};
  assign elig    = elig_rd | elig_wr;

  assign winner  = arb_pick(elig, pref);
  assign win_wr  = elig_wr[winner];

  assign m_cmd_valid = |elig;
  assign m_wr_valid  = m_cmd_valid & win_wr;
  assign cmd_hs      = m_cmd_valid & m_cmd_accept;
  // A write is only taken when command and data are accepted in the same cycle.
  assign take        = cmd_hs & (~win_wr | m_wr_accept);

  assign p0_cmd_accept = take & (winner == 1'b0);
  assign p1_cmd_accept = take & (winner == 1'b1);
  assign p0_wr_accept  = take & win_wr & (winner == 1'b0);
  assign p1_wr_accept  = take & win_wr & (winner == 1'b1);

  always_comb begin
    m_cmd_read       = p0_cmd_read;
    m_cmd_wrap       = p0_cmd_wrap;
    m_cmd_nonsec     = p0_cmd_nonsec;
    m_cmd_addr       = p0_cmd_addr;
    m_cmd_data_size  = p0_cmd_data_size;
    m_cmd_burst_size = p0_cmd_burst_size;
    m_wr_last        = p0_wr_last;
    m_wr_data        = p0_wr_data;
    m_wr_mask        = p0_wr_mask;
    if (winner == 1'b1) begin
      m_cmd_read       = p1_cmd_read;
      m_cmd_wrap       = p1_cmd_wrap;
      m_cmd_nonsec     = p1_cmd_nonsec;
      m_cmd_addr       = p1_cmd_addr;
      m_cmd_data_size  = p1_cmd_data_size;
      m_cmd_burst_size = p1_cmd_burst_size;
      m_wr_last        = p1_wr_last;
      m_wr_data        = p1_wr_data;
      m_wr_mask        = p1_wr_mask;
    end
  end

`ifdef ALB_MSS_MEM_ARB_FIXED_PRIO_EN
  assign pref = 1'b0;
`else
  port_id_t pref_q, pref_d;

  // After any command handshake the loser becomes the preferred port.
  always_comb begin
    pref_d = pref_q;
    if (cmd_hs) pref_d = ~winner;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) pref_q <= 1'b0;
    else        pref_q <= pref_d;
  end

  assign pref = pref_q;
`endif

  // Response handshakes; a response with an empty queue is accepted and dropped.
  assign rd_resp          = m_rd_valid | m_err_rd;
  assign wr_resp          = m_wr_done | m_err_wr;
  assign m_rd_accept      = rdq_empty | ((rdq_head == 1'b1) ? p1_rd_accept : p0_rd_accept);
  assign m_wr_resp_accept = wrq_empty |
                            ((wrq_head == 1'b1) ? p1_wr_resp_accept : p0_wr_resp_accept);
  assign rd_pop           = rd_resp & m_rd_accept & ~rdq_empty;
  assign wr_pop           = wr_resp & m_wr_resp_accept & ~wrq_empty;

  assign rd_sel[0] = ~rdq_empty & (rdq_head == 1'b0);
  assign rd_sel[1] = ~rdq_empty & (rdq_head == 1'b1);
  assign wr_sel[0] = ~wrq_empty & (wrq_head == 1'b0);
  assign wr_sel[1] = ~wrq_empty & (wrq_head == 1'b1);

  assign p0_rd_valid     = rd_sel[0] & m_rd_valid;
  assign p0_rd_last      = rd_sel[0] & m_rd_last;
  assign p0_rd_excl_ok   = rd_sel[0] & m_rd_excl_ok;
  assign p0_err_rd       = rd_sel[0] & m_err_rd;
  assign p0_rd_data      = rd_sel[0] ? m_rd_data : '0;
  assign p1_rd_valid     = rd_sel[1] & m_rd_valid;
  assign p1_rd_last      = rd_sel[1] & m_rd_last;
  assign p1_rd_excl_ok   = rd_sel[1] & m_rd_excl_ok;
  assign p1_err_rd       = rd_sel[1] & m_err_rd;
  assign p1_rd_data      = rd_sel[1] ? m_rd_data : '0;

  assign p0_wr_done      = wr_sel[0] & m_wr_done;
  assign p0_wr_excl_done = wr_sel[0] & m_wr_excl_done;
  assign p0_err_wr       = wr_sel[0] & m_err_wr;
  assign p1_wr_done      = wr_sel[1] & m_wr_done;
  assign p1_wr_excl_done = wr_sel[1] & m_wr_excl_done;
  assign p1_err_wr       = wr_sel[1] & m_err_wr;

  alb_mss_mem_arb_idq #(
    .Depth (OUTST)
  ) u_rd_idq (
    .clk     (clk),
    .rst_b   (rst_b),
    .push    (take & ~win_wr),
    .push_id (winner),
    .pop     (rd_pop),
    .full    (rdq_full),
    .empty   (rdq_empty),
    .head    (rdq_head)
  );

  alb_mss_mem_arb_idq #(
    .Depth (OUTST)
  ) u_wr_idq (
    .clk     (clk),
    .rst_b   (rst_b),
    .push    (take & win_wr),
    .push_id (winner),
    .pop     (wr_pop),
    .full    (wrq_full),
    .empty   (wrq_empty),
    .head    (wrq_head)
  );

  // Protocol checks: orphan responses and multi-beat writes.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      assert (!(rd_resp && rdq_empty)) else $error("read response with no outstanding read");
      assert (!(wr_resp && wrq_empty)) else $error("write response with no outstanding write");
      assert (!(take && win_wr && !m_wr_last)) else $error("multi-beat write not supported");
    end
  end

endmodule

// File: tb/tb_alb_mss_mem_ibp_arb.sv
module tb_alb_mss_mem_ibp_arb;
  import alb_mss_mem_ibp_arb_pkg::*;

`ifdef ALB_MSS_MEM_ARB_FIXED_PRIO_EN
  localparam bit FixedPrio = 1'b1;
`else
  localparam bit FixedPrio = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  logic p0_cmd_valid, p0_cmd_read, p0_cmd_wrap, p0_cmd_nonsec, p0_cmd_accept;
  logic [31:0] p0_cmd_addr;
  logic [2:0] p0_cmd_data_size;
  logic [3:0] p0_cmd_burst_size;
  logic p0_wr_valid, p0_wr_last, p0_wr_accept;
  logic [127:0] p0_wr_data, p0_rd_data;
  logic [15:0] p0_wr_mask;
  logic p0_rd_valid, p0_rd_last, p0_rd_excl_ok, p0_err_rd, p0_rd_accept;
  logic p0_wr_done, p0_wr_excl_done, p0_err_wr, p0_wr_resp_accept;
  logic p1_cmd_valid, p1_cmd_read, p1_cmd_wrap, p1_cmd_nonsec, p1_cmd_accept;
  logic [31:0] p1_cmd_addr;
  logic [2:0] p1_cmd_data_size;
  logic [3:0] p1_cmd_burst_size;
  logic p1_wr_valid, p1_wr_last, p1_wr_accept;
  logic [127:0] p1_wr_data, p1_rd_data;
  logic [15:0] p1_wr_mask;
  logic p1_rd_valid, p1_rd_last, p1_rd_excl_ok, p1_err_rd, p1_rd_accept;
  logic p1_wr_done, p1_wr_excl_done, p1_err_wr, p1_wr_resp_accept;
  logic m_cmd_valid, m_cmd_read, m_cmd_wrap, m_cmd_nonsec, m_cmd_accept;
  logic [31:0] m_cmd_addr;
  logic [2:0] m_cmd_data_size;
  logic [3:0] m_cmd_burst_size;
  logic m_wr_valid, m_wr_last, m_wr_accept;
  logic [127:0] m_wr_data, m_rd_data;
  logic [15:0] m_wr_mask;
  logic m_rd_valid, m_rd_last, m_rd_excl_ok, m_err_rd, m_rd_accept;
  logic m_wr_done, m_wr_excl_done, m_err_wr, m_wr_resp_accept;

  alb_mss_mem_ibp_arb #(.a_w(32), .OUTST(4)) dut (
    .clk(clk), .rst_b(rst_b),
    .p0_cmd_valid(p0_cmd_valid), .p0_cmd_read(p0_cmd_read), .p0_cmd_wrap(p0_cmd_wrap),
    .p0_cmd_nonsec(p0_cmd_nonsec), .p0_cmd_addr(p0_cmd_addr),
    .p0_cmd_data_size(p0_cmd_data_size), .p0_cmd_burst_size(p0_cmd_burst_size),
    .p0_cmd_accept(p0_cmd_accept), .p0_wr_valid(p0_wr_valid), .p0_wr_last(p0_wr_last),
    .p0_wr_data(p0_wr_data), .p0_wr_mask(p0_wr_mask), .p0_wr_accept(p0_wr_accept),
    .p0_rd_valid(p0_rd_valid), .p0_rd_last(p0_rd_last), .p0_rd_excl_ok(p0_rd_excl_ok),
    .p0_err_rd(p0_err_rd), .p0_rd_data(p0_rd_data), .p0_rd_accept(p0_rd_accept),
    .p0_wr_done(p0_wr_done), .p0_wr_excl_done(p0_wr_excl_done), .p0_err_wr(p0_err_wr),
    .p0_wr_resp_accept(p0_wr_resp_accept),
    .p1_cmd_valid(p1_cmd_valid), .p1_cmd_read(p1_cmd_read), .p1_cmd_wrap(p1_cmd_wrap),
    .p1_cmd_nonsec(p1_cmd_nonsec), .p1_cmd_addr(p1_cmd_addr),
    .p1_cmd_data_size(p1_cmd_data_size), .p1_cmd_burst_size(p1_cmd_burst_size),
    .p1_cmd_accept(p1_cmd_accept), .p1_wr_valid(p1_wr_valid), .p1_wr_last(p1_wr_last),
    .p1_wr_data(p1_wr_data), .p1_wr_mask(p1_wr_mask), .p1_wr_accept(p1_wr_accept),
    .p1_rd_valid(p1_rd_valid), .p1_rd_last(p1_rd_last), .p1_rd_excl_ok(p1_rd_excl_ok),
    .p1_err_rd(p1_err_rd), .p1_rd_data(p1_rd_data), .p1_rd_accept(p1_rd_accept),
    .p1_wr_done(p1_wr_done), .p1_wr_excl_done(p1_wr_excl_done), .p1_err_wr(p1_err_wr),
    .p1_wr_resp_accept(p1_wr_resp_accept),
    .m_cmd_valid(m_cmd_valid), .m_cmd_read(m_cmd_read), .m_cmd_wrap(m_cmd_wrap),
    .m_cmd_nonsec(m_cmd_nonsec), .m_cmd_addr(m_cmd_addr),
    .m_cmd_data_size(m_cmd_data_size), .m_cmd_burst_size(m_cmd_burst_size),
    .m_cmd_accept(m_cmd_accept), .m_wr_valid(m_wr_valid), .m_wr_last(m_wr_last),
    .m_wr_data(m_wr_data), .m_wr_mask(m_wr_mask), .m_wr_accept(m_wr_accept),
    .m_rd_valid(m_rd_valid), .m_rd_last(m_rd_last), .m_rd_excl_ok(m_rd_excl_ok),
    .m_err_rd(m_err_rd), .m_rd_data(m_rd_data), .m_rd_accept(m_rd_accept),
    .m_wr_done(m_wr_done), .m_wr_excl_done(m_wr_excl_done), .m_err_wr(m_err_wr),
    .m_wr_resp_accept(m_wr_resp_accept)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_cmd_valid = 0; p0_cmd_read = 0; p0_cmd_wrap = 0; p0_cmd_nonsec = 0;
    p0_cmd_addr = '0; p0_cmd_data_size = 3'd4; p0_cmd_burst_size = '0;
    p0_wr_valid = 0; p0_wr_last = 1; p0_wr_data = '0; p0_wr_mask = '0;
    p0_rd_accept = 1; p0_wr_resp_accept = 1;
    p1_cmd_valid = 0; p1_cmd_read = 0; p1_cmd_wrap = 0; p1_cmd_nonsec = 0;
    p1_cmd_addr = '0; p1_cmd_data_size = 3'd2; p1_cmd_burst_size = '0;
    p1_wr_valid = 0; p1_wr_last = 1; p1_wr_data = '0; p1_wr_mask = '0;
    p1_rd_accept = 1; p1_wr_resp_accept = 1;
    m_cmd_accept = 1; m_wr_accept = 1;
    m_rd_valid = 0; m_rd_last = 0; m_rd_excl_ok = 0; m_err_rd = 0; m_rd_data = '0;
    m_wr_done = 0; m_wr_excl_done = 0; m_err_wr = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_b = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1;
  endtask

  logic [127:0] a5_data;
  logic         exp_w;
  logic         exp_order[$];
  int           g0, g1;

  initial begin
    a5_data = {16{8'hA5}};
    // Reset state
    idle();
    rst_b = 0;
    #2;
    check_eq("rst_m_cmd_valid", m_cmd_valid, 0);
    check_eq("rst_m_wr_valid", m_wr_valid, 0);
    check_eq("rst_p0_cmd_accept", p0_cmd_accept, 0);
    check_eq("rst_p1_rd_valid", p1_rd_valid, 0);
    do_reset();

    // Lone read on port 0, response routed to port 0 only
    p0_cmd_valid = 1; p0_cmd_read = 1; p0_cmd_addr = 32'h100;
    #2;
    check_eq("t1_m_cmd_valid", m_cmd_valid, 1);
    check_eq("t1_m_cmd_addr", m_cmd_addr, 32'h100);
    check_eq("t1_m_cmd_read", m_cmd_read, 1);
    check_eq("t1_p0_cmd_accept", p0_cmd_accept, 1);
    check_eq("t1_p1_cmd_accept", p1_cmd_accept, 0);
    step();
    idle();
    m_rd_valid = 1; m_rd_last = 1; m_rd_data = a5_data;
    #2;
    check_eq("t1_p0_rd_valid", p0_rd_valid, 1);
    check_eq("t1_p0_rd_data", p0_rd_data, a5_data);
    check_eq("t1_p1_rd_valid", p1_rd_valid, 0);
    check_eq("t1_p1_rd_data", p1_rd_data, 0);
    check_eq("t1_m_rd_accept", m_rd_accept, 1);
    step();
    idle();

    // Both ports read every cycle for 8 cycles; responses follow one cycle behind
    do_reset();
    g0 = 0; g1 = 0;
    for (int k = 0; k < 9; k++) begin
      p0_cmd_valid = (k < 8); p0_cmd_read = 1; p0_cmd_addr = 32'h10;
      p1_cmd_valid = (k < 8); p1_cmd_read = 1; p1_cmd_addr = 32'h20;
      m_rd_valid = (k > 0); m_rd_last = 1; m_rd_data = 128'(k);
      #2;
      if (k < 8) begin
        exp_w = FixedPrio ? 1'b0 : ((k % 2) == 1);
        check_eq($sformatf("t2_p0_acc_%0d", k), p0_cmd_accept, !exp_w);
        check_eq($sformatf("t2_p1_acc_%0d", k), p1_cmd_accept, exp_w);
        check_eq($sformatf("t2_addr_%0d", k), m_cmd_addr, exp_w ? 32'h20 : 32'h10);
        check_eq($sformatf("t2_dsize_%0d", k), m_cmd_data_size, exp_w ? 3'd2 : 3'd4);
        g0 += int'(p0_cmd_accept);
        g1 += int'(p1_cmd_accept);
        exp_order.push_back(exp_w);
      end
      if (k > 0) begin
        exp_w = exp_order.pop_front();
        check_eq($sformatf("t2_p0_rdv_%0d", k), p0_rd_valid, !exp_w);
        check_eq($sformatf("t2_p1_rdv_%0d", k), p1_rd_valid, exp_w);
        check_eq($sformatf("t2_rdata_%0d", k), exp_w ? p1_rd_data : p0_rd_data, 128'(k));
      end
      step();
    end
    idle();
    check_eq("t2_p0_grants", 32'(g0), FixedPrio ? 32'd8 : 32'd4);
    check_eq("t2_p1_grants", 32'(g1), FixedPrio ? 32'd0 : 32'd4);

    // Port 1 write stalled by m_wr_accept=0 for 3 cycles
    do_reset();
    p1_cmd_valid = 1; p1_cmd_read = 0; p1_cmd_addr = 32'h200;
    p1_wr_valid = 1; p1_wr_last = 1; p1_wr_data = 128'hDEAD_BEEF; p1_wr_mask = 16'hFFFF;
    m_wr_accept = 0;
    for (int c = 0; c < 3; c++) begin
      #2;
      check_eq($sformatf("t3_stall_cacc_%0d", c), p1_cmd_accept, 0);
      check_eq($sformatf("t3_stall_wacc_%0d", c), p1_wr_accept, 0);
      check_eq($sformatf("t3_stall_mwv_%0d", c), m_wr_valid, 1);
      step();
    end
    m_wr_accept = 1;
    #2;
    check_eq("t3_cacc", p1_cmd_accept, 1);
    check_eq("t3_wacc", p1_wr_accept, 1);
    check_eq("t3_wdata", m_wr_data, 128'hDEAD_BEEF);
    check_eq("t3_wmask", m_wr_mask, 16'hFFFF);
    step();
    idle();
    m_wr_done = 1;
    #2;
    check_eq("t3_p1_wr_done", p1_wr_done, 1);
    check_eq("t3_p0_wr_done", p0_wr_done, 0);
    check_eq("t3_m_wr_resp_acc", m_wr_resp_accept, 1);
    step();
    idle();

    // Fill the read queue, 5th read stalls, a write still passes, one pop frees it
    do_reset();
    for (int i = 0; i < 4; i++) begin
      p0_cmd_valid = 1; p0_cmd_read = 1; p0_cmd_addr = 32'h300 + 32'(i);
      #2;
      check_eq($sformatf("t4_fill_%0d", i), p0_cmd_accept, 1);
      step();
    end
    p1_cmd_valid = 1; p1_cmd_read = 0; p1_cmd_addr = 32'h400;
    p1_wr_valid = 1; p1_wr_data = 128'h1234;
    #2;
    check_eq("t4_rd5_stall", p0_cmd_accept, 0);
    check_eq("t4_wr_cacc", p1_cmd_accept, 1);
    check_eq("t4_wr_wacc", p1_wr_accept, 1);
    check_eq("t4_wr_addr", m_cmd_addr, 32'h400);
    step();
    p1_cmd_valid = 0; p1_wr_valid = 0;
    m_rd_valid = 1; m_rd_last = 1; p0_rd_accept = 0;
    #2;
    check_eq("t4_hold_rdv", p0_rd_valid, 1);
    check_eq("t4_hold_macc", m_rd_accept, 0);
    check_eq("t4_hold_stall", p0_cmd_accept, 0);
    check_eq("t4_hold_mcv", m_cmd_valid, 0);
    step();
    p0_rd_accept = 1;
    #2;
    check_eq("t4_pop_macc", m_rd_accept, 1);
    check_eq("t4_pop_stall", p0_cmd_accept, 0);
    step();
    m_rd_valid = 0;
    #2;
    check_eq("t4_rd5_go", p0_cmd_accept, 1);
    step();
    idle();

    // Async reset with two reads outstanding
    do_reset();
    for (int i = 0; i < 2; i++) begin
      p0_cmd_valid = 1; p0_cmd_read = 1; p0_cmd_addr = 32'h600;
      #2;
      check_eq($sformatf("t5_issue_%0d", i), p0_cmd_accept, 1);
      step();
    end
    idle();
    m_rd_valid = 1; m_rd_last = 1; m_rd_data = 128'h55; p0_rd_accept = 0;
    #2;
    check_eq("t5_pre_rdv", p0_rd_valid, 1);
    rst_b = 0;
    #1;
    check_eq("t5_async_rdv", p0_rd_valid, 0);
    check_eq("t5_async_rdata", p0_rd_data, 0);
    check_eq("t5_async_mcv", m_cmd_valid, 0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1;
    p1_cmd_valid = 1; p1_cmd_read = 1; p1_cmd_addr = 32'h500;
    #2;
    check_eq("t5_p1_cacc", p1_cmd_accept, 1);
    check_eq("t5_p0_cacc", p0_cmd_accept, 0);
    step();
    idle();
    m_rd_valid = 1; m_rd_last = 1; m_rd_data = 128'h77;
    #2;
    check_eq("t5_p1_rdv", p1_rd_valid, 1);
    check_eq("t5_p0_rdv", p0_rd_valid, 0);
    check_eq("t5_p1_rdata", p1_rd_data, 128'h77);
    step();
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/alb_mss_mem_ibp_arb.md
Name: alb_mss_mem_ibp_arb

Overview:
- Two-port round-robin IBP arbiter placed in front of one single-port IBP memory controller (alb_mss_mem_ctrl).
- Grants one single-beat command per cycle to the downstream controller.
- Records the grantee's ID in per-channel order queues and steers the in-order read and write responses back to the originating port.
- Used in the testbench memory subsystem when two masters share one memory region.

Parameters:
- a_w, 32, address width (32 or 40).
- OUTST, 4, max outstanding reads, and separately max outstanding writes, tracked per channel; power of 2, range 2..16.

Ports:
- clk  in  1  clock.
- rst_b  in  1  asynchronous active-low reset.
- pN_cmd_valid/cmd_read/cmd_wrap/cmd_nonsec  in  1 each  port N command, N=0,1.
- pN_cmd_addr  in  a_w  command address.
- pN_cmd_data_size  in  3  data size.
- pN_cmd_burst_size  in  4  burst size.
- pN_cmd_accept  out  1  command accepted.
- pN_wr_valid/wr_last  in  1 each  write data valid / last beat.
- pN_wr_data  in  128  write data.
- pN_wr_mask  in  16  write byte mask.
- pN_wr_accept  out  1  write data accepted.
- pN_rd_valid/rd_last/rd_excl_ok/err_rd  out  1 each  read response.
- pN_rd_data  out  128  read data.
- pN_rd_accept  in  1  read response accepted.
- pN_wr_done/wr_excl_done/err_wr  out  1 each  write response.
- pN_wr_resp_accept  in  1  write response accepted.
- m_*  ports  opposite direction of pN_*  same widths  downstream single IBP (cmd, wr, rd, wr-resp groups).

Behaviour:
- Reset: all pN_* outputs and m_cmd_valid/m_wr_valid 0; rr pointer = port 0 preferred; both order queues empty.
- Eligibility, port N:
  - Read: pN_cmd_valid & pN_cmd_read & rd queue not full.
  - Write: pN_cmd_valid & !pN_cmd_read & pN_wr_valid & wr queue not full (command and its single data beat move together).
- Arbitration is combinational, zero latency.
  - One eligible port wins.
  - Two eligible ports: winner = rr preferred port.
  - rr pointer toggles to the loser only on m_cmd_valid & m_cmd_accept.
- Forwarding:
  - m_cmd_* = winner's command fields; m_cmd_valid = any eligible.
  - For a write: m_wr_valid = 1; m_wr_data/mask/last = winner's.
  - pN_cmd_accept = winner==N & m_cmd_accept.
  - pN_wr_accept = winner==N & write & m_cmd_accept & m_wr_accept.
- Atomic write handshake:
  - Write is taken only when m_cmd_accept & m_wr_accept both high in the same cycle.
  - Otherwise neither pN_cmd_accept nor pN_wr_accept is raised for that write.
- Order queues: two FIFOs of 1-bit IDs, depth OUTST.
  - Push the grantee ID on an accepted read or write respectively.
  - Pop on the response handshake (m_rd_valid|m_err_rd)&m_rd_accept, or (m_wr_done|m_err_wr)&m_wr_resp_accept.
  - Simultaneous push/pop allowed; occupancy unchanged.
  - Full: blocks eligibility on that channel only.
- Response routing:
  - Responses go to the queue head ID only; the other port's response outputs are 0.
  - m_rd_accept = head port's rd_accept; rd_data passed through unmodified.
  - Response on an empty queue is a protocol error: drop it, assert m_rd_accept/m_wr_resp_accept, and trigger a sim $error.
- Unsupported traffic: multi-beat bursts (wr_last=0) are unsupported; sim $error if pN_wr_last==0 on an accepted write.
- Asynchronous reset mid-operation clears queues and pointer immediately; outstanding responses are lost.

Optional Feature:
- Macro: ALB_MSS_MEM_ARB_FIXED_PRIO_EN.
  - Defined: port 0 always wins ties; rr pointer removed.
  - Undefined: round-robin as above.

Decomposition:
- Shared defines file alb_mss_mem_defines.v holds:
  - ALB_MSS_MEM_ARB_NPORT = 2.
  - ID width = 1.
  - IBP field widths (128 data, 16 mask).
- Sub-module alb_mss_mem_arb_idq: parameterised ID order FIFO with push, pop, full, empty and head outputs; instantiated twice (rd, wr).

Test Plan:
- P0 read addr 0x100 alone, downstream always ready -> m_cmd_valid same cycle, p0_cmd_accept=1; response data 0xA5.. goes to p0 only, p1_rd_valid=0.
- P0 and P1 reads every cycle for 8 cycles -> grants alternate 0,1,0,1…; exactly 4 per port; responses return in grant order to the matching port.
- P1 write 0x200 with data valid but m_wr_accept=0 for 3 cycles -> no accept for 3 cycles; single accept on cycle 4; wr_done routed to p1.
- Issue OUTST=4 reads with rd_accept held 0 -> 5th read stalled; writes from the other port still granted; one pop frees the 5th read the next cycle.
- Reset asserted with 2 reads outstanding -> all outputs 0 asynchronously; after release, first read response is routed correctly from an empty-queue start.
- Build with ALB_MSS_MEM_ARB_FIXED_PRIO_EN, both ports requesting continuously -> port 0 granted every cycle, port 1 never.
